rpxx_ctrl: RTL and testbench

RPxx drive function controller: decodes function writes to RPCS1, validates the disk address, sequences seek/search/data-transfer operations and drives the `state`/`incSECTOR` outputs consumed by the RPER1 error register. It is the producer side of the drive error-reporting interface. It sits inside each RPxx drive, between the RH11 register decode and the sector transfer engine.

---
 rtl/rpxx_ctrl_pkg.sv | 73 +++++++
 rtl/rpxx_addrchk.sv | 29 ++
 rtl/rpxx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rpxx_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rpxx_ctrl_pkg.sv
// Shared RPxx controller definitions: state encodings, function codes and CS1/DA/DC field helpers.
package rpxx_ctrl_pkg;

    typedef enum logic [4:0] {
        StIdle    = 5'd0,
        StClear   = 5'd1,
        StIllFun  = 5'd2,
        StInvAddr = 5'd3,
        StWrLock  = 5'd4,
        StSeek    = 5'd5,
        StSearch  = 5'd6,
        StXfer    = 5'd7,
        StDone    = 5'd8,
        StPreset  = 5'd9
    } rpStateT;

    localparam logic [4:0] FnNop     = 5'o00;
    localparam logic [4:0] FnUnload  = 5'o01;
    localparam logic [4:0] FnSeek    = 5'o02;
    localparam logic [4:0] FnRecal   = 5'o03;
    localparam logic [4:0] FnClear   = 5'o04;
    localparam logic [4:0] FnRelease = 5'o05;
    localparam logic [4:0] FnOffset  = 5'o06;
    localparam logic [4:0] FnReturn  = 5'o07;
    localparam logic [4:0] FnPreset  = 5'o10;
    localparam logic [4:0] FnPackAck = 5'o11;
    localparam logic [4:0] FnSearch  = 5'o14;
    localparam logic [4:0] FnWrChk   = 5'o24;
    localparam logic [4:0] FnWrChkH  = 5'o25;
    localparam logic [4:0] FnWrite   = 5'o30;
    localparam logic [4:0] FnWriteH  = 5'o31;
    localparam logic [4:0] FnRead    = 5'o34;
    localparam logic [4:0] FnReadH   = 5'o35;

    function automatic logic fieldGo(input logic [35:0] d);
        return d[0];
    endfunction

    function automatic logic [4:0] fieldFn(input logic [35:0] d);
        return d[5:1];
    endfunction

    function automatic logic [5:0] fieldSa(input logic [15:0] da);
        return da[5:0];
    endfunction

    function automatic logic [4:0] fieldTa(input logic [15:0] da);
        return da[12:8];
    endfunction

    function automatic logic [9:0] fieldDca(input logic [15:0] dc);
        return dc[9:0];
    endfunction

    function automatic logic fnLegal(input logic [4:0] fn);
        return (fn <= FnPackAck) ||
               (fn inside {FnSearch, FnWrChk, FnWrChkH, FnWrite, FnWriteH, FnRead, FnReadH});
    endfunction

    // Functions that complete without touching the disk address.
    function automatic logic fnNoAddr(input logic [4:0] fn);
        return fn inside {FnNop, FnUnload, FnRelease, FnOffset, FnReturn, FnPackAck};
    endfunction

    function automatic logic fnIsXfer(input logic [4:0] fn);
        return (fn >= FnWrChk) && (fn <= FnReadH);
    endfunction

    function automatic logic fnIsWrite(input logic [4:0] fn);
        return (fn == FnWrite) || (fn == FnWriteH);
    endfunction

endpackage

// File: rtl/rpxx_addrchk.sv
// Combinational desired-address checks: out-of-range (invalid) and last-address (AOE) compares.
module rpxx_addrchk
    import rpxx_ctrl_pkg::*;
(
    input  logic [15:0] rpDA,
    input  logic [15:0] rpDC,
    input  logic [5:0]  lastSECTOR,
    input  logic [5:0]  lastTRACK,
    input  logic [9:0]  lastCYL,
    output logic        invAddr,
    output logic        lastAddr
);

    logic [5:0] sa;
    logic [5:0] ta;
    logic [9:0] dca;

    always_comb begin
        sa       = fieldSa(rpDA);
        ta       = {1'b0, fieldTa(rpDA)};
        dca      = fieldDca(rpDC);
        invAddr  = (sa > lastSECTOR) || (ta > lastTRACK) || (dca > lastCYL);
        lastAddr = (sa == lastSECTOR) && (ta == lastTRACK) && (dca == lastCYL);
    end

    logic unusedBits;
    assign unusedBits = ^{rpDA[15:13], rpDA[7:6], rpDC[15:10]};

endmodule

// File: rtl/rpxx_ctrl.sv
// RPxx drive function controller. Define RPXX_SEEK_DELAY_EN to give SEEK/SEARCH their full
// SEEK_DELAY/SEARCH_DELAY durations; otherwise each lasts one cycle and no counter is built.
module rpxx_ctrl
    import rpxx_ctrl_pkg::*;
#(
    parameter int unsigned SEEK_DELAY   = 200,
    parameter int unsigned SEARCH_DELAY = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [35:0] rpDATAI,
    input  logic        rpcs1WRITE,
    input  logic [15:0] rpDA,
    input  logic [15:0] rpDC,
    input  logic [5:0]  lastSECTOR,
    input  logic [5:0]  lastTRACK,
    input  logic [9:0]  lastCYL,
    input  logic        rpWRL,
    input  logic        wcZERO,
    input  logic        xferACK,
    output logic [4:0]  state,
    output logic        rpDRY,
    output logic        xferREQ,
    output logic        incSECTOR,
    output logic        presetPULSE,
    output logic        setATA
);

    if (SEEK_DELAY < 1 || SEEK_DELAY >= (1 << 20) ||
        SEARCH_DELAY < 1 || SEARCH_DELAY >= (1 << 20)) begin : gBadDelay
        $error("rpxx_ctrl: SEEK_DELAY/SEARCH_DELAY out of range");
    end

    rpStateT    stateQ, stateD;
    logic [4:0] fnQ, fnD;
    logic       errQ, errD;
    logic       xferFnQ, xferFnD;
    logic       incD;
    logic       loadSeek, loadSearch;
    logic       delayDone;
    logic       invAddr, lastAddr;
    logic [4:0] fn;

    rpxx_addrchk uAddrChk (
        .rpDA       (rpDA),
        .rpDC       (rpDC),
        .lastSECTOR (lastSECTOR),
        .lastTRACK  (lastTRACK),
        .lastCYL    (lastCYL),
        .invAddr    (invAddr),
        .lastAddr   (lastAddr)
    );

    assign fn    = fieldFn(rpDATAI);
    assign state = stateQ;

`ifdef RPXX_SEEK_DELAY_EN
    logic [19:0] cntQ;

    assign delayDone = (cntQ <= 20'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntQ <= '0;
        end else if (clr) begin
            cntQ <= '0;
        end else if (loadSeek) begin
            cntQ <= 20'(SEEK_DELAY);
        end else if (loadSearch) begin
            cntQ <= 20'(SEARCH_DELAY);
        end else if (stateQ == StSeek || stateQ == StSearch) begin
            cntQ <= delayDone ? 20'd0 : cntQ - 20'd1;
        end
    end
`else
    logic unusedLoad;
    assign unusedLoad = loadSeek ^ loadSearch;
    assign delayDone  = 1'b1;
`endif

    always_comb begin
        stateD     = stateQ;
        fnD        = fnQ;
        errD       = errQ;
        xferFnD    = xferFnQ;
        incD       = 1'b0;
        loadSeek   = 1'b0;
        loadSearch = 1'b0;
        if (clr) begin
            stateD  = StIdle;
            errD    = 1'b0;
            xferFnD = 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (rpcs1WRITE && fieldGo(rpDATAI)) begin
                        fnD     = fn;
                        errD    = 1'b0;
                        xferFnD = fnIsXfer(fn);
                        if (!fnLegal(fn)) begin
                            stateD = StIllFun;
                            errD   = 1'b1;
                        end else if (fn == FnClear) begin
                            stateD = StClear;
                        end else if (fn == FnPreset) begin
                            stateD = StPreset;
                        end else if (fnNoAddr(fn)) begin
                            stateD = StDone;
                        end else if (invAddr) begin
                            stateD = StInvAddr;
                            errD   = 1'b1;
                        end else if (fnIsWrite(fn) && rpWRL) begin
                            stateD = StWrLock;
                            errD   = 1'b1;
                        end else if (fn == FnSearch) begin
                            stateD     = StSearch;
                            loadSearch = 1'b1;
                        end else begin
                            stateD   = StSeek;
                            loadSeek = 1'b1;
                        end
                    end
                end
                StSeek: begin
                    if (delayDone) begin
                        stateD = (fnQ == FnSeek || fnQ == FnRecal) ? StDone : StXfer;
                    end
                end
                StSearch: begin
                    if (delayDone) stateD = StDone;
                end
                StXfer: begin
                    if (xferACK) begin
                        incD = 1'b1;
                        if (wcZERO || lastAddr) stateD = StDone;
                        if (lastAddr) errD = 1'b1;
                    end
                end
                StIllFun, StInvAddr, StWrLock, StPreset: stateD = StDone;
                StClear, StDone:                         stateD = StIdle;
                default:                                 stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= StIdle;
            fnQ         <= '0;
            errQ        <= 1'b0;
            xferFnQ     <= 1'b0;
            rpDRY       <= 1'b1;
            xferREQ     <= 1'b0;
            incSECTOR   <= 1'b0;
            presetPULSE <= 1'b0;
            setATA      <= 1'b0;
        end else begin
            stateQ      <= stateD;
            fnQ         <= fnD;
            errQ        <= errD;
            xferFnQ     <= xferFnD;
            rpDRY       <= (stateD == StIdle);
            xferREQ     <= (stateD == StXfer);
            incSECTOR   <= incD;
            presetPULSE <= (stateD == StPreset);
            // A clean data transfer finishes silently; everything else raises attention.
            setATA      <= (stateD == StDone) && !(xferFnD && !errD);
        end
    end

    logic unusedData;
    assign unusedData = ^rpDATAI[35:6];

endmodule

// File: tb/tb_rpxx_ctrl.sv
// Directed bench for rpxx_ctrl: table of single-function vectors plus multi-cycle sequences.
module tb_rpxx_ctrl;

    localparam logic [4:0] IDLE = 5'd0, CLEAR = 5'd1, ILLFUN = 5'd2, INVADDR = 5'd3;
    localparam logic [4:0] WRLOCK = 5'd4, SEEK = 5'd5, SEARCH = 5'd6, XFER = 5'd7;
    localparam logic [4:0] DONE = 5'd8, PRESET = 5'd9;
`ifdef RPXX_SEEK_DELAY_EN
    localparam int SEEK_CYC   = 4;
    localparam int SEARCH_CYC = 3;
`else
    localparam int SEEK_CYC   = 1;
    localparam int SEARCH_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, clr, rpcs1WRITE, rpWRL, wcZERO, xferACK;
    logic [35:0] rpDATAI;
    logic [15:0] rpDA, rpDC;
    logic [5:0]  lastSECTOR, lastTRACK;
    logic [9:0]  lastCYL;
    logic [4:0]  state;
    logic        rpDRY, xferREQ, incSECTOR, presetPULSE, setATA;

    int nTests = 0;
    int nFail  = 0;

    rpxx_ctrl #(.SEEK_DELAY(4), .SEARCH_DELAY(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .rpDATAI     (rpDATAI),
        .rpcs1WRITE  (rpcs1WRITE),
        .rpDA        (rpDA),
        .rpDC        (rpDC),
        .lastSECTOR  (lastSECTOR),
        .lastTRACK   (lastTRACK),
        .lastCYL     (lastCYL),
        .rpWRL       (rpWRL),
        .wcZERO      (wcZERO),
        .xferACK     (xferACK),
        .state       (state),
        .rpDRY       (rpDRY),
        .xferREQ     (xferREQ),
        .incSECTOR   (incSECTOR),
        .presetPULSE (presetPULSE),
        .setATA      (setATA)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [35:0] data;
        logic [15:0] da;
        logic [15:0] dc;
        logic        wrl;
        logic [4:0]  s1, s2, s3;
        logic        ata1, ata2, pre1;
    } vecT;

    vecT vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one CS1 write; returns at the negedge after the accepting edge.
    task automatic issue(input logic [35:0] data, input logic [15:0] da, input logic [15:0] dc);
        @(negedge clk);
        rpDATAI    = data;
        rpDA       = da;
        rpDC       = dc;
        rpcs1WRITE = 1'b1;
        @(negedge clk);
        rpcs1WRITE = 1'b0;
    endtask

    task automatic waitFor(input logic [4:0] target, input string name);
        int n = 0;
        while (state !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, state, target);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; rpcs1WRITE = 1'b0; rpWRL = 1'b0; wcZERO = 1'b0; xferACK = 1'b0;
        rpDATAI = '0; rpDA = '0; rpDC = '0;
        lastSECTOR = 6'd21; lastTRACK = 6'd18; lastCYL = 10'd814;

        vecs[0] = '{"illfun37",  36'o77, 16'd0,    16'd0,   1'b0, ILLFUN,  DONE, IDLE, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"invSA",     36'o05, 16'd22,   16'd0,   1'b0, INVADDR, DONE, IDLE, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"wrlock",    36'o61, 16'd0,    16'd0,   1'b1, WRLOCK,  DONE, IDLE, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"unload",    36'o03, 16'd0,    16'd0,   1'b0, DONE,    IDLE, IDLE, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"clear",     36'o11, 16'd0,    16'd0,   1'b0, CLEAR,   IDLE, IDLE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"preset",    36'o21, 16'd0,    16'd0,   1'b0, PRESET,  DONE, IDLE, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{"noGo",      36'o04, 16'd0,    16'd0,   1'b0, IDLE,    IDLE, IDLE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"illfun26",  36'o55, 16'd0,    16'd0,   1'b0, ILLFUN,  DONE, IDLE, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{"invTA",     36'o71, 16'h1300, 16'd0,   1'b0, INVADDR, DONE, IDLE, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{"invDCA",    36'o31, 16'd0,    16'd815, 1'b0, INVADDR, DONE, IDLE, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst/state", state, IDLE);
        check("rst/rpDRY", rpDRY, 1'b1);
        check("rst/xferREQ", xferREQ, 1'b0);
        check("rst/incSECTOR", incSECTOR, 1'b0);
        check("rst/presetPULSE", presetPULSE, 1'b0);
        check("rst/setATA", setATA, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            rpWRL = vecs[i].wrl;
            issue(vecs[i].data, vecs[i].da, vecs[i].dc);
            check($sformatf("%s/s1", vecs[i].name), state, vecs[i].s1);
            check($sformatf("%s/rpDRY", vecs[i].name), rpDRY, vecs[i].s1 == IDLE);
            check($sformatf("%s/ata1", vecs[i].name), setATA, vecs[i].ata1);
            check($sformatf("%s/pre1", vecs[i].name), presetPULSE, vecs[i].pre1);
            check($sformatf("%s/req1", vecs[i].name), xferREQ, 1'b0);
            @(negedge clk);
            check($sformatf("%s/s2", vecs[i].name), state, vecs[i].s2);
            check($sformatf("%s/ata2", vecs[i].name), setATA, vecs[i].ata2);
            check($sformatf("%s/pre2", vecs[i].name), presetPULSE, 1'b0);
            check($sformatf("%s/req2", vecs[i].name), xferREQ, 1'b0);
            @(negedge clk);
            check($sformatf("%s/s3", vecs[i].name), state, vecs[i].s3);
            rpWRL = 1'b0;
        end

        // Read: full seek, then three sectors with word count running out on the third.
        issue(36'o71, 16'd5, 16'd0);
        check("read/seek", state, SEEK);
        n = 0;
        while (state === SEEK && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("read/seekCycles", n, SEEK_CYC);
        check("read/xfer", state, XFER);
        check("read/xferREQ", xferREQ, 1'b1);
        for (int k = 0; k < 3; k++) begin
            xferACK = 1'b1;
            wcZERO  = (k == 2);
            @(negedge clk);
            xferACK = 1'b0;
            wcZERO  = 1'b0;
            check($sformatf("read/inc%0d", k), incSECTOR, 1'b1);
            check($sformatf("read/state%0d", k), state, (k == 2) ? DONE : XFER);
            check($sformatf("read/ata%0d", k), setATA, 1'b0);
            if (k < 2) begin
                @(negedge clk);
                check($sformatf("read/incGap%0d", k), incSECTOR, 1'b0);
            end
        end
        @(negedge clk);
        check("read/idle", state, IDLE);
        check("read/reqOff", xferREQ, 1'b0);

        // Transfer at the last address ends with AOE and raises attention.
        issue(36'o71, 16'h1215, 16'd814);
        waitFor(XFER, "aoe/reachXfer");
        xferACK = 1'b1;
        @(negedge clk);
        xferACK = 1'b0;
        check("aoe/inc", incSECTOR, 1'b1);
        check("aoe/done", state, DONE);
        check("aoe/ata", setATA, 1'b1);
        @(negedge clk);
        check("aoe/idle", state, IDLE);

        // Search: delay then DONE with attention.
        issue(36'o31, 16'd3, 16'd100);
        check("search/state", state, SEARCH);
        n = 0;
        while (state === SEARCH && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("search/cycles", n, SEARCH_CYC);
        check("search/done", state, DONE);
        check("search/ata", setATA, 1'b1);

        // ACK outside XFER is ignored.
        @(negedge clk);
        xferACK = 1'b1;
        @(negedge clk);
        xferACK = 1'b0;
        check("idleAck/inc", incSECTOR, 1'b0);
        check("idleAck/state", state, IDLE);

        // Drive clear in the middle of a transfer.
        issue(36'o71, 16'd5, 16'd0);
        waitFor(XFER, "clr/reachXfer");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr/state", state, IDLE);
        check("clr/xferREQ", xferREQ, 1'b0);
        check("clr/ata", setATA, 1'b0);
        check("clr/rpDRY", rpDRY, 1'b1);
        @(negedge clk);
        check("clr/ataAfter", setATA, 1'b0);

        // Asynchronous reset while seeking.
        issue(36'o71, 16'd5, 16'd0);
        check("rstSeek/seek", state, SEEK);
        #1 rst = 1'b1;
        #1;
        check("rstSeek/state", state, IDLE);
        check("rstSeek/rpDRY", rpDRY, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstSeek/stays", state, IDLE);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
